// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit timing.
// Used by uart_tx today and intended for the future uart_rx.
package uart_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_STOP_BITS    = 1;
   localparam int UART_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Total clock cycles occupied by one 8N1 frame on the line.
   function automatic int uart_frame_clks(input int clks_per_bit);
      return (1 + UART_DATA_BITS + UART_STOP_BITS) * clks_per_bit;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags derived from the occupancy count.
// Push while full and pop while empty are ignored; push and pop together leave the count unchanged.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_next_s;
   logic             full_r;
   logic             empty_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = push && !full_r;
   assign pop_s  = pop && !empty_r;
   assign rdata  = mem_r[rd_ptr_r];
   assign full   = full_r;
   assign empty  = empty_r;

   // Next occupancy count from the qualified push/pop pair.
   always_comb begin
      count_next_s = count_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CW'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Pointers, count and flags; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == CW'(DEPTH));
         empty_r <= (count_next_s == CW'(0));
      end
   end

   // Storage array; contents are don't-care while empty so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter driven by the cpu byte handshake (tx_req / tx_ready / tx_data).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry sync_fifo between the handshake and the FSM.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_req,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       txd,
   output logic       busy
);

   localparam int               BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

   uart_state_e state_r;
   uart_state_e next_state_s;
   logic [BW-1:0] baud_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          txd_r;
   logic          busy_r;
   logic          baud_end_s;
   logic          start_s;
   logic          busy_next_s;
   logic [7:0]    load_data_s;

   assign baud_end_s = (baud_r == BAUD_LAST);
   assign txd        = txd_r;
   assign busy       = busy_r;

`ifdef UART_TX_FIFO_EN
   logic       fifo_full_s;
   logic       fifo_empty_s;
   logic       push_s;
   logic       pop_s;
   logic [7:0] fifo_rdata_s;

   assign push_s      = tx_req && !fifo_full_s;
   assign pop_s       = (state_r == IDLE) && !fifo_empty_s;
   assign start_s     = !fifo_empty_s;
   assign load_data_s = fifo_rdata_s;
   assign tx_ready    = !fifo_full_s;
   // A pop always launches START, so only a non-popping cycle can leave the FIFO holding data in IDLE.
   assign busy_next_s = (next_state_s != IDLE) || push_s || (!fifo_empty_s && !pop_s);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata (tx_data),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );
`else
   logic tx_ready_r;

   assign start_s     = tx_req && tx_ready_r;
   assign load_data_s = tx_data;
   assign tx_ready    = tx_ready_r;
   assign busy_next_s = (next_state_s != IDLE);

   // Ready mirrors the upcoming IDLE state, so it drops right after an accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ready_r <= 1'b1;
      end else begin
         tx_ready_r <= (next_state_s == IDLE);
      end
   end
`endif

   // Frame sequencing: each non-idle state lasts whole bit periods.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) next_state_s = START;
            else         next_state_s = IDLE;
         end
         START: begin
            if (baud_end_s) next_state_s = DATA;
            else            next_state_s = START;
         end
         DATA: begin
            if (baud_end_s && (bit_cnt_r == BIT_LAST)) next_state_s = STOP;
            else                                      next_state_s = DATA;
         end
         STOP: begin
            if (baud_end_s) next_state_s = IDLE;
            else            next_state_s = STOP;
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, baud/bit counters, shifter and the registered line driver.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         baud_r    <= '0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         txd_r     <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= busy_next_s;

         // Line level follows the current state, giving one cycle from accept to start bit.
         case (state_r)
            IDLE:    txd_r <= 1'b1;
            START:   txd_r <= 1'b0;
            DATA:    txd_r <= shift_r[0];
            STOP:    txd_r <= 1'b1;
            default: txd_r <= 1'b1;
         endcase

         if (state_r == IDLE) begin
            baud_r <= '0;
         end else if (baud_end_s) begin
            baud_r <= '0;
         end else begin
            baud_r <= baud_r + BW'(1);
         end

         if (state_r == IDLE) begin
            bit_cnt_r <= 3'd0;
         end else if ((state_r == DATA) && baud_end_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
         end

         if ((state_r == IDLE) && start_s) begin
            shift_r <= load_data_s;
         end else if ((state_r == DATA) && baud_end_s) begin
            shift_r <= {1'b0, shift_r[7:1]};
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line monitor decodes txd frames.
// Runs the single-byte path by default and the FIFO scenarios when UART_TX_FIFO_EN is defined.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
   localparam int LAT         = 2;
   localparam int EXP_FRAMES  = 10;
`else
   localparam int LAT         = 1;
   localparam int EXP_FRAMES  = 3;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_req = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       txd;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int frames = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_req   (tx_req),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .txd      (txd),
      .busy     (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      tx_req  = 1'b1;
      tx_data = b;
      tick();
      tx_req  = 1'b0;
   endtask

   // Edges after the accept edge until txd first reads low.
   task automatic wait_start(output int n);
      n = 0;
      while (txd !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
      repeat (CPB + 2) tick();
   endtask

   // Line monitor: decode each frame at mid-bit, require flat bits, compare with the queue.
   initial begin : monitor
      logic             prev;
      logic [FRAME-1:0] smp;
      logic [7:0]       got;
      logic             aborted;
      logic             flat;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && prev === 1'b1 && txd === 1'b0) begin
            aborted = 1'b0;
            smp     = '0;
            smp[0]  = txd;
            for (int i = 1; i < FRAME; i++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               smp[i] = txd;
            end
            if (!aborted) begin
               flat = 1'b1;
               for (int b = 0; b < 10; b++)
                  for (int k = 0; k < CPB; k++)
                     if (smp[b*CPB+k] !== smp[b*CPB]) flat = 1'b0;
               for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*CPB + CPB/2];
               chk("frame_shape", {29'd0, smp[0], smp[FRAME-1], flat}, 32'd3);
               frames++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame actual=%0h expected=none", got);
               end else begin
                  chk("frame_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
               end
            end
         end
         prev = txd;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      logic [7:0] fb [6];
      fb = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};

      rst = 1'b1;
      tick();
      chk("reset_txd",   {31'd0, txd},      32'd1);
      chk("reset_ready", {31'd0, tx_ready}, 32'd1);
      chk("reset_busy",  {31'd0, busy},     32'd0);
      tick();
      rst = 1'b0;
      n = 0;
      repeat (100) begin
         tick();
         if (txd !== 1'b1) n++;
      end
      chk("idle_txd_glitches", n, 0);

      exp_q.push_back(8'h55);
      send(8'h55);
`ifndef UART_TX_FIFO_EN
      chk("ready_after_accept", {31'd0, tx_ready}, 32'd0);
`endif
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_start(n);
      chk("start_latency", n, LAT);
      repeat (38) tick();
      chk("busy_before_end", {31'd0, busy}, 32'd1);
      chk("txd_stop_bit",    {31'd0, txd},  32'd1);
`ifndef UART_TX_FIFO_EN
      chk("ready_before_end", {31'd0, tx_ready}, 32'd0);
`endif
      tick();
      chk("busy_end",  {31'd0, busy},     32'd0);
      chk("ready_end", {31'd0, tx_ready}, 32'd1);
      repeat (CPB + 2) tick();

`ifndef UART_TX_FIFO_EN
      exp_q.push_back(8'h41);
      send(8'h41);
      repeat (9) tick();
      chk("ready_while_busy", {31'd0, tx_ready}, 32'd0);
      send(8'h42);
      wait_idle(60);
      chk("frames_after_drop", frames, 2);
`else
      exp_q.push_back(8'h48);
      exp_q.push_back(8'h69);
      exp_q.push_back(8'h0A);
      tx_req = 1'b1;
      tx_data = 8'h48; chk("burst_ready0", {31'd0, tx_ready}, 32'd1); tick();
      tx_data = 8'h69; chk("burst_ready1", {31'd0, tx_ready}, 32'd1); tick();
      tx_data = 8'h0A; chk("burst_ready2", {31'd0, tx_ready}, 32'd1); tick();
      tx_req = 1'b0;
      n = 2;
      while (busy !== 1'b0 && n < 400) begin
         tick();
         n++;
      end
      chk("burst_busy_fall", n, 123);
      repeat (CPB + 2) tick();

      tx_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_data = fb[i];
         chk("full_ready", {31'd0, tx_ready}, (i < 5) ? 32'd1 : 32'd0);
         if (i < 5) exp_q.push_back(fb[i]);
         tick();
      end
      tx_req = 1'b0;
      n = 5;
      while (tx_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("full_ready_rise", n, 42);
      wait_idle(300);
`endif

      send(8'hA5);
`ifdef UART_TX_FIFO_EN
      send(8'h33);
      repeat (15) tick();
`else
      repeat (16) tick();
`endif
      rst = 1'b1;
      tick();
      chk("midframe_rst_txd",   {31'd0, txd},      32'd1);
      chk("midframe_rst_ready", {31'd0, tx_ready}, 32'd1);
      chk("midframe_rst_busy",  {31'd0, busy},     32'd0);
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      exp_q.push_back(8'h0F);
      send(8'h0F);
      wait_start(n);
      chk("post_rst_latency", n, LAT);
      wait_idle(100);

      chk("queue_empty", exp_q.size(), 0);
      chk("frame_count", frames, EXP_FRAMES);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
